// File: rtl/wbuf_drain_if.sv
// Bus bundle for the write-buffer drain engine: FIFO head/pop side plus the
// single-outstanding memory write handshake. master = drain engine, slave = FIFO/memory.
interface wbuf_drain_if #(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_STRB  = W_DATA / 8,
    parameter int W_ENTRY = W_ADDR + W_DATA + W_STRB
);
    logic               FifoEmpty_i;
    logic [W_ENTRY-1:0] FifoData_i;
    logic               FifoRead_o;
    logic               MemReq_o;
    logic [W_ADDR-1:0]  MemAddr_o;
    logic [W_DATA-1:0]  MemWData_o;
    logic [W_STRB-1:0]  MemStrb_o;
    logic               MemReqAck_i;
    logic               MemDone_i;
    logic               MemErr_i;

    modport master (
        input  FifoEmpty_i, FifoData_i, MemReqAck_i, MemDone_i, MemErr_i,
        output FifoRead_o, MemReq_o, MemAddr_o, MemWData_o, MemStrb_o
    );

    modport slave (
        output FifoEmpty_i, FifoData_i, MemReqAck_i, MemDone_i, MemErr_i,
        input  FifoRead_o, MemReq_o, MemAddr_o, MemWData_o, MemStrb_o
    );
endinterface

// File: rtl/wbuf_drain.sv
// Write-buffer drain engine: pops one FIFO entry at a time, issues it as a memory write
// and covers it with an in-flight address match until completion. Retry on error via WBUF_DRAIN_RETRY_EN.
module wbuf_drain #(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int W_STRB    = W_DATA / 8,
    parameter int W_ENTRY   = W_ADDR + W_DATA + W_STRB,
    parameter int C_RETRIES = 2
) (
    input  logic              sClk_i,
    input  logic              snRst_i,
    wbuf_drain_if.master      bus,
    input  logic              HitEn_i,
    input  logic [W_ADDR-1:0] HitAddr_i,
    output logic              InflightHit_o,
    output logic              Busy_o,
    output logic              Error_o,
    output logic [W_ADDR-1:0] ErrAddr_o,
    input  logic              ErrClr_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [W_ADDR-1:0] h_addr_reg;
    logic [W_DATA-1:0] h_data_reg;
    logic [W_STRB-1:0] h_strb_reg;
    logic              error_reg;
    logic [W_ADDR-1:0] err_addr_reg;

    logic capture;
    logic fifo_read;
    logic mem_req;
    logic complete;
    logic err_final;

`ifdef WBUF_DRAIN_RETRY_EN
    localparam int W_CNT = (C_RETRIES > 0) ? $clog2(C_RETRIES + 1) : 1;
    logic [W_CNT-1:0] retry_cnt_reg;
    logic             retry;
`endif

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        fifo_read  = 1'b0;
        mem_req    = 1'b0;
        complete   = 1'b0;
        err_final  = 1'b0;
`ifdef WBUF_DRAIN_RETRY_EN
        retry      = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                fifo_read = ~bus.FifoEmpty_i;
                if (!bus.FifoEmpty_i) begin
                    capture    = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                // A zero-wait slave may answer in the accept cycle itself.
                if (bus.MemReqAck_i) begin
                    if (bus.MemDone_i) begin
                        complete = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.MemDone_i) begin
                    complete = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (complete) begin
            if (!bus.MemErr_i) begin
                state_next = S_IDLE;
            end
`ifdef WBUF_DRAIN_RETRY_EN
            else if (retry_cnt_reg < W_CNT'(C_RETRIES)) begin
                retry      = 1'b1;
                state_next = S_REQ;
            end
`endif
            else begin
                err_final  = 1'b1;
                state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            h_addr_reg <= '0;
            h_data_reg <= '0;
            h_strb_reg <= '0;
        end else if (capture) begin
            h_addr_reg <= bus.FifoData_i[W_ADDR-1:0];
            h_data_reg <= bus.FifoData_i[W_ADDR+W_DATA-1:W_ADDR];
            h_strb_reg <= bus.FifoData_i[W_ENTRY-1:W_ADDR+W_DATA];
        end
    end

`ifdef WBUF_DRAIN_RETRY_EN
    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            retry_cnt_reg <= '0;
        end else if (capture) begin
            retry_cnt_reg <= '0;
        end else if (retry) begin
            retry_cnt_reg <= retry_cnt_reg + 1'b1;
        end
    end
`endif

    // A new failure outranks a simultaneous clear so no error is ever lost.
    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            error_reg    <= 1'b0;
            err_addr_reg <= '0;
        end else if (err_final) begin
            error_reg    <= 1'b1;
            err_addr_reg <= h_addr_reg;
        end else if (ErrClr_i) begin
            error_reg    <= 1'b0;
        end
    end

    assign bus.FifoRead_o = fifo_read;
    assign bus.MemReq_o   = mem_req;
    assign bus.MemAddr_o  = h_addr_reg;
    assign bus.MemWData_o = h_data_reg;
    assign bus.MemStrb_o  = h_strb_reg;

    assign Busy_o        = (state_reg != S_IDLE);
    assign InflightHit_o = HitEn_i & Busy_o & (h_addr_reg == HitAddr_i);
    assign Error_o       = error_reg;
    assign ErrAddr_o     = err_addr_reg;

endmodule
